// File: rtl/mem_stage.sv
// Memory stage: drives a req/gnt/rvalid data bus for loads/stores, stalls upstream
// while an access is outstanding, and registers the MEM/WB results.
typedef enum logic [3:0] {
  OP_OTHER, OP_ADD,
  OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
  OP_SB, OP_SH, OP_SW
} alu_ctrl_e;

module mem_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tb_update_i,
  input  logic [XLEN-1:0] pcM_i,
  input  logic [XLEN-1:0] instrM_i,
  input  alu_ctrl_e       operationM_i,
  input  logic [XLEN-1:0] rdM_data_i,
  input  logic [4:0]      rdM_addr_i,
  input  logic            rdM_wr_ena_i,
  input  logic            memM_wr_ena_i,
  input  logic [XLEN-1:0] memM_addr_i,
  input  logic [XLEN-1:0] memM_wr_data_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] forwM_data_o,
  output logic [XLEN-1:0] pcM_o,
  output logic [XLEN-1:0] instrM_o,
  output logic [XLEN-1:0] rdM_data_o,
  output logic [4:0]      rdM_addr_o,
  output logic            rdM_wr_ena_o,
  output logic            misaligned_o,
  output logic            tb_update_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

  state_e          state, state_nxt;
  logic [1:0]      off;
  logic            is_load, is_store, is_half, is_word, misaligned, mem_op;
  logic [XLEN-1:0] lane, load_data;

  assign off          = memM_addr_i[1:0];
  assign is_load      = operationM_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store     = memM_wr_ena_i;
  assign is_half      = operationM_i inside {OP_LH, OP_LHU, OP_SH};
  assign is_word      = operationM_i inside {OP_LW, OP_SW};
  assign misaligned   = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign mem_op       = (is_load | is_store) & ~misaligned;

  assign dmem_we_o    = is_store;
  assign dmem_addr_o  = {memM_addr_i[XLEN-1:2], 2'b00};
  assign forwM_data_o = rdM_data_i;
  assign lane         = dmem_rdata_i >> {off, 3'b000};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = memM_wr_data_i;
    case (operationM_i)
      OP_SB, OP_LB, OP_LBU: begin
        dmem_be_o    = 4'b0001 << off;
        dmem_wdata_o = {4{memM_wr_data_i[7:0]}};
      end
      OP_SH, OP_LH, OP_LHU: begin
        dmem_be_o    = 4'b0011 << off;
        dmem_wdata_o = {2{memM_wr_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = lane;
    case (operationM_i)
      OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      OP_LBU:  load_data = {24'd0, lane[7:0]};
      OP_LHU:  load_data = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_op) begin
        if (dmem_gnt_i) state_nxt = is_store ? IDLE : WAIT_RESP;
        else            state_nxt = REQ;
      end
      REQ:       if (dmem_gnt_i) state_nxt = is_store ? IDLE : WAIT_RESP;
      WAIT_RESP: if (dmem_rvalid_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A granted store completes in the grant cycle; a load waits for rvalid.
  always_comb begin
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        dmem_req_o = mem_op;
        stall_o    = mem_op & ~(dmem_gnt_i & is_store);
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = ~(dmem_gnt_i & is_store);
      end
      WAIT_RESP: stall_o = ~dmem_rvalid_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcM_o        <= RESET_PC;
      instrM_o     <= 32'h0000_0013;
      rdM_data_o   <= '0;
      rdM_addr_o   <= '0;
      rdM_wr_ena_o <= 1'b0;
      misaligned_o <= 1'b0;
      tb_update_o  <= 1'b0;
    end else if (!stall_o) begin
      pcM_o        <= pcM_i;
      instrM_o     <= instrM_i;
      rdM_addr_o   <= rdM_addr_i;
      rdM_data_o   <= is_load ? load_data : rdM_data_i;
      rdM_wr_ena_o <= rdM_wr_ena_i & ~misaligned;
      misaligned_o <= (is_load | is_store) & misaligned;
      tb_update_o  <= tb_update_i;
    end else begin
      rdM_wr_ena_o <= 1'b0;
      misaligned_o <= 1'b0;
      tb_update_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized bus slave, byte-level memory reference model,
// and a retire scoreboard fed at issue time and drained by an independent monitor.
module tb_mem_stage;

  typedef struct {
    logic [31:0] pc, instr, rd_data;
    logic [4:0]  rd_addr;
    logic        wr_ena, mis, chk_data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } bus_t;

  logic clk = 0, rst = 0;
  logic tb_update_i = 0, rdM_wr_ena_i = 0, memM_wr_ena_i = 0;
  logic [31:0] pcM_i = 0, instrM_i = 0, rdM_data_i = 0, memM_addr_i = 0, memM_wr_data_i = 0;
  logic [4:0]  rdM_addr_i = 0;
  alu_ctrl_e   operationM_i = OP_OTHER;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;
  logic        dmem_req, dmem_we, stall, rdM_wr_ena_o, misaligned_o, tb_update_o;
  logic [31:0] dmem_addr, dmem_wdata, forw, pcM_o, instrM_o, rdM_data_o;
  logic [3:0]  dmem_be;
  logic [4:0]  rdM_addr_o;

  int total = 0, bad = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];
  logic [31:0] ref_mem[16];
  logic [31:0] bus_mem[16];
  int force_gnt = -1, force_rv = -1;
  int req_seen = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic [3:0]  last_be = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  mem_stage dut (
    .clk_i(clk), .rst_i(rst), .tb_update_i(tb_update_i), .pcM_i(pcM_i), .instrM_i(instrM_i),
    .operationM_i(operationM_i), .rdM_data_i(rdM_data_i), .rdM_addr_i(rdM_addr_i),
    .rdM_wr_ena_i(rdM_wr_ena_i), .memM_wr_ena_i(memM_wr_ena_i), .memM_addr_i(memM_addr_i),
    .memM_wr_data_i(memM_wr_data_i), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .stall_o(stall), .forwM_data_o(forw), .pcM_o(pcM_o), .instrM_o(instrM_o),
    .rdM_data_o(rdM_data_o), .rdM_addr_o(rdM_addr_o), .rdM_wr_ena_o(rdM_wr_ena_o),
    .misaligned_o(misaligned_o), .tb_update_o(tb_update_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int op_size(alu_ctrl_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  // Loaded value from plain arithmetic on the selected byte/halfword.
  function automatic logic [31:0] load_val(alu_ctrl_e op, logic [31:0] w, logic [1:0] off);
    logic [31:0] v;
    v = w >> (8 * off);
    case (op)
      OP_LB:  begin v = v & 32'hFF;   return (v >= 128)   ? v - 32'd256   : v; end
      OP_LH:  begin v = v & 32'hFFFF; return (v >= 32768) ? v - 32'd65536 : v; end
      OP_LBU: return v & 32'hFF;
      OP_LHU: return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  task automatic nop();
    operationM_i  = OP_OTHER;
    memM_wr_ena_i = 0;
    rdM_wr_ena_i  = 0;
    tb_update_i   = 0;
  endtask

  task automatic issue(input alu_ctrl_e op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] alu, input logic [4:0] rd, input logic rwe,
                       input bit use_lit, input logic [31:0] lit, output int stalls);
    exp_t e;
    bus_t b;
    int sz, idx;
    logic [1:0] off;
    bit ld, st, mis, sampled;
    sz  = op_size(op);
    off = addr[1:0];
    idx = int'(addr[5:2]);
    ld  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    st  = op inside {OP_SB, OP_SH, OP_SW};
    mis = (sz == 2 && off[0]) || (sz == 4 && off != 0);
    pc_cnt += 4;
    pcM_i = pc_cnt; instrM_i = $urandom; operationM_i = op; rdM_data_i = alu;
    rdM_addr_i = rd; rdM_wr_ena_i = rwe; memM_wr_ena_i = st; memM_addr_i = addr;
    memM_wr_data_i = wd; tb_update_i = 1;
    if ((ld || st) && !mis) begin
      b.we = st; b.addr = {addr[31:2], 2'b00}; b.be = 0; b.wdata = 0;
      for (int k = 0; k < sz; k++) b.be[int'(off) + k] = 1'b1;
      for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wd[8*(k % (sz == 0 ? 4 : sz)) +: 8];
      bus_q.push_back(b);
    end
    if (st && !mis)
      for (int k = 0; k < sz; k++) ref_mem[idx][8*(int'(off) + k) +: 8] = wd[8*k +: 8];
    e.pc = pcM_i; e.instr = instrM_i; e.rd_addr = rd;
    e.rd_data  = ld ? load_val(op, ref_mem[idx], off) : alu;
    if (use_lit) e.rd_data = lit;
    e.chk_data = !mis;
    e.wr_ena   = rwe & !mis;
    e.mis      = (ld || st) && mis;
    exp_q.push_back(e);
    stalls = 0;
    for (int c = 0; ; c++) begin
      @(negedge clk); #2;
      if (c == 0) chk("forw_data", forw, alu);
      sampled = stall;
      @(posedge clk);
      if (!sampled) break;
      stalls++;
      if (c > 60) begin chk("issue_timeout", 1, 0); break; end
    end
    #1;
  endtask

  // Bus slave: random grant latency, response 1+ cycles after grant, stray rvalids when idle.
  initial begin
    bus_t b;
    int gwait = 0, rv_wait = 0, pend_idx = 0;
    bit pend = 0, in_req = 0;
    forever begin
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = $urandom;
      if (pend) begin
        if (rv_wait == 0) begin
          dmem_rvalid = 1; dmem_rdata = bus_mem[pend_idx]; pend = 0;
        end else rv_wait--;
      end else begin
        if (dmem_req && !rst) begin
          req_seen++;
          if (!in_req) begin
            in_req = 1;
            gwait = (force_gnt >= 0) ? force_gnt : $urandom_range(0, 3);
          end
          if (gwait == 0) begin
            dmem_gnt = 1; in_req = 0;
            last_addr = dmem_addr; last_be = dmem_be; last_wdata = dmem_wdata;
            if (bus_q.size() == 0) chk("unexpected_req", 1, 0);
            else begin
              b = bus_q.pop_front();
              chk("bus_we", dmem_we, b.we);
              chk("bus_addr", dmem_addr, b.addr);
              chk("bus_be", dmem_be, b.be);
              if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
            end
            if (dmem_we) begin
              for (int k = 0; k < 4; k++)
                if (dmem_be[k]) bus_mem[dmem_addr[5:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
            end else begin
              pend = 1; pend_idx = int'(dmem_addr[5:2]);
              rv_wait = (force_rv >= 0) ? force_rv : $urandom_range(0, 2);
            end
          end else gwait--;
        end
        if (!dmem_gnt && $urandom_range(0, 7) == 0) dmem_rvalid = 1;
      end
    end
  end

  // Retire monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (tb_update_o) begin
        if (exp_q.size() == 0) chk("unexpected_retire", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wb_pc", pcM_o, e.pc);
          chk("wb_instr", instrM_o, e.instr);
          chk("wb_rd_addr", rdM_addr_o, e.rd_addr);
          chk("wb_wr_ena", rdM_wr_ena_o, e.wr_ena);
          chk("wb_misaligned", misaligned_o, e.mis);
          if (e.chk_data) chk("wb_rd_data", rdM_data_o, e.rd_data);
        end
      end else begin
        chk("bubble_wr_ena", rdM_wr_ena_o, 0);
        chk("bubble_misaligned", misaligned_o, 0);
      end
    end
  end

  initial begin
    alu_ctrl_e ops[10] = '{OP_ADD, OP_OTHER, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    alu_ctrl_e op;
    int st, r0, w;
    logic [31:0] m;
    for (int i = 0; i < 16; i++) begin m = $urandom; ref_mem[i] = m; bus_mem[i] = m; end
    nop();
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pcM_o, 32'h8000_0000);
    chk("rst_instr", instrM_o, 32'h13);
    chk("rst_rd_data", rdM_data_o, 0);
    chk("rst_wr_ena", rdM_wr_ena_o, 0);
    chk("rst_tb_update", tb_update_o, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    @(posedge clk); #1;

    force_gnt = 0; force_rv = 0;
    ref_mem[0] = 32'hDEAD_BEEF; bus_mem[0] = 32'hDEAD_BEEF;
    issue(OP_LW, 32'h100, $urandom, $urandom, 5'd3, 1, 1, 32'hDEAD_BEEF, st);
    chk("lw_stall_cycles", st, 1);
    ref_mem[0] = 32'h80FF_0000; bus_mem[0] = 32'h80FF_0000;
    issue(OP_LB, 32'h103, $urandom, $urandom, 5'd4, 1, 1, 32'hFFFF_FF80, st);
    chk("lb_stall_cycles", st, 1);
    issue(OP_LBU, 32'h103, $urandom, $urandom, 5'd5, 1, 1, 32'h0000_0080, st);
    issue(OP_LH, 32'h102, $urandom, $urandom, 5'd6, 1, 1, 32'hFFFF_80FF, st);

    force_gnt = 3;
    issue(OP_SH, 32'h202, 32'h1234_ABCD, $urandom, 5'd0, 0, 0, 0, st);
    chk("sh_stall_cycles", st, 3);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_addr", last_addr, 32'h200);

    force_gnt = 0;
    r0 = req_seen;
    issue(OP_LW, 32'h101, $urandom, $urandom, 5'd7, 1, 0, 0, st);
    chk("mis_stall_cycles", st, 0);
    chk("mis_no_req", req_seen - r0, 0);
    issue(OP_ADD, 32'h104, $urandom, 32'd7, 5'd8, 1, 1, 32'd7, st);
    chk("add_stall_cycles", st, 0);

    // Reset while a load waits for its response.
    force_rv = 4;
    pc_cnt += 4;
    pcM_i = pc_cnt; instrM_i = $urandom; operationM_i = OP_LW; memM_wr_ena_i = 0;
    memM_addr_i = 32'h108; rdM_addr_i = 5'd9; rdM_wr_ena_i = 1; tb_update_i = 1;
    bus_q.push_back('{we: 1'b0, addr: 32'h108, be: 4'hF, wdata: 32'h0});
    @(posedge clk); #1;
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_req", dmem_req, 0);
    rst = 1; nop(); #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_pc", pcM_o, 32'h8000_0000);
    chk("midrst_instr", instrM_o, 32'h13);
    @(posedge clk); #1 rst = 0;
    repeat (8) begin @(negedge clk); chk("post_rst_no_wb", rdM_wr_ena_o, 0); end
    @(posedge clk); #1;

    force_gnt = -1; force_rv = -1;
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) begin nop(); @(posedge clk); #1; end
      issue(op, 32'h100 + $urandom_range(0, 63), $urandom, $urandom, 5'($urandom),
            1'($urandom_range(0, 3) != 0), 0, 0, st);
    end
    nop();
    w = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && w < 100) begin @(posedge clk); w++; end
    repeat (3) @(posedge clk);
    chk("drain_retire_q", exp_q.size(), 0);
    chk("drain_bus_q", bus_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM register outputs of the execute stage and drives a req/gnt/rvalid data-memory bus for loads and stores.
- Generates byte lanes and store-data replication, and sign- or zero-extends load data.
- Raises a pipeline stall while an access is in flight, then registers the MEM/WB results toward writeback.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_PC, 32'h8000_0000, reset value of pcM_o.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
tb_update_i  in  1  testbench retire marker from EX/MEM
pcM_i  in  XLEN  instruction PC
instrM_i  in  XLEN  instruction word
operationM_i  in  alu_ctrl_e  decoded operation (LB/LH/LW/LBU/LHU/SB/SH/SW/other)
rdM_data_i  in  XLEN  ALU result
rdM_addr_i  in  5  destination register
rdM_wr_ena_i  in  1  register write enable
memM_wr_ena_i  in  1  store enable
memM_addr_i  in  XLEN  byte address
memM_wr_data_i  in  XLEN  store data (rs2)
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1=write
dmem_addr_o  out  XLEN  word address {memM_addr_i[31:2],2'b00}
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  XLEN  read data
stall_o  out  1  hold IF/ID/EX and the EX/MEM register (comb)
forwM_data_o  out  XLEN  = rdM_data_i (comb) for EX forwarding
pcM_o, instrM_o  out  XLEN  MEM/WB copies
rdM_data_o  out  XLEN  writeback data
rdM_addr_o  out  5  writeback register
rdM_wr_ena_o  out  1  writeback enable
misaligned_o  out  1  registered one-cycle flag for a misaligned access
tb_update_o  out  1  retire marker to WB

Behaviour:
- Reset: async on rst_i=1, state→IDLE. pcM_o=RESET_PC, instrM_o=32'h00000013, all other registered outputs 0. dmem_req_o and stall_o go 0 immediately because both are derived from state plus inputs.
- Classification: is_load = operation in {LB,LH,LW,LBU,LHU}. is_store = memM_wr_ena_i.
- Misalignment: halfword ops with addr[0]≠0, and word ops with addr[1:0]≠0.
- mem_op = (is_load|is_store) & !misaligned.
- Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
- Store data: wdata = {4{wd[7:0]}} for SB, {2{wd[15:0]}} for SH, wd for SW. dmem_we_o=is_store.
- Load extraction: lane = dmem_rdata_i>>(8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- FSM states: IDLE, REQ, WAIT_RESP.
  - IDLE: dmem_req_o=mem_op.
    - gnt & store → done, stay IDLE, stall_o=0.
    - gnt & load → WAIT_RESP, stall_o=1.
    - no gnt & mem_op → REQ, stall_o=1.
    - non-mem op: stall_o=0.
  - REQ: dmem_req_o=1; address, be, we and wdata are held stable by the upstream stall.
    - gnt & store → IDLE, stall_o=0.
    - gnt & load → WAIT_RESP, stall_o=1.
    - else stay, stall_o=1.
  - WAIT_RESP: dmem_req_o=0.
    - rvalid → IDLE, stall_o=0.
    - else stay, stall_o=1.
- rvalid is only honoured in WAIT_RESP; it never arrives in the same cycle as its gnt. rvalid in IDLE/REQ is ignored.
- MEM/WB register update: on every edge with stall_o=0, capture pc, instr and rd_addr.
  - rdM_data_o = extended load data for loads, else rdM_data_i.
  - rdM_wr_ena_o = rdM_wr_ena_i & !misaligned.
  - misaligned_o = (is_load|is_store) & misaligned.
  - tb_update_o = tb_update_i.
- Bubbles: on edges with stall_o=1, rdM_wr_ena_o, tb_update_o and misaligned_o are forced to 0; pc, instr and data hold.
- Latency: a store granted in its first cycle costs 0 stall cycles. A load costs at least 1 stall cycle (gnt at N, rvalid at N+1, written to MEM/WB at end of N+1).
- Misaligned access: no bus request and no stall; reported the next cycle via misaligned_o; writeback suppressed.
- Reset mid-access: FSM returns to IDLE; a response arriving afterward is dropped.

Test Plan:
- LW at 0x100, gnt in the same cycle, rvalid next cycle with 0xDEADBEEF → stall_o high exactly 1 cycle; rdM_data_o=0xDEADBEEF and rdM_wr_ena_o=1 one edge later.
- LB at 0x103 with rdata 0x80FF_0000 → 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LH at 0x102 → 0xFFFF_80FF.
- SH at 0x202, wd=0x1234_ABCD, gnt held low 3 cycles → dmem_be_o=4'b1100, wdata=0xABCD_ABCD, addr=0x200, stall_o high 3 cycles.
- LW at 0x101 → dmem_req_o never asserted, stall_o=0, next cycle misaligned_o=1 and rdM_wr_ena_o=0.
- ADD with rdM_data_i=7 → no request, forwM_data_o=7 combinationally, rdM_data_o=7 next edge.
- rst_i pulsed while in WAIT_RESP → req/stall drop immediately, pcM_o=0x8000_0000, instrM_o=0x13, and a later rvalid causes no writeback.
